jtframe_dwnld_pack: RTL

ROM-download formatter that sits between the SPI data-io byte stream and the SDRAM programming port of the frame. It converts the byte-wide stream (`ioctl_addr`, `ioctl_data`, `ioctl_wr`) into bank-addressed, byte-masked SDRAM write commands (`prog_*`). A small FIFO absorbs SDRAM refresh and arbitration latency. The block also produces the `dwnld_busy` signal that keeps the game in reset until every downloaded byte has been committed to SDRAM.

---
 rtl/jtframe_dwnld_pack.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/jtframe_dwnld_pack.sv
// Byte-stream ROM download to bank-addressed, byte-masked SDRAM writes through a 4-deep queue.
// prog_we rises 2 cycles after ioctl_wr; held until prog_rdy; bytes arriving on a full queue are dropped (overflow).
module jtframe_dwnld_pack #(
  parameter int          SDRAMW    = 23,
  parameter logic [24:0] BA1_START = 25'h40_0000,
  parameter logic [24:0] BA2_START = 25'h80_0000,
  parameter logic [24:0] BA3_START = 25'hC0_0000,
  parameter logic        SWAB      = 1'b0
) (
  input  logic              clk_rom,
  input  logic              rst_n,
  input  logic              downloading,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_data,
  input  logic              ioctl_wr,
  output logic [SDRAMW-1:0] prog_addr,
  output logic [15:0]       prog_data,
  output logic [1:0]        prog_mask,
  output logic [1:0]        prog_ba,
  output logic              prog_we,
  output logic              prog_rd,
  input  logic              prog_rdy,
  output logic              dwnld_busy,
  output logic              overflow
);

  localparam int OW = SDRAMW + 1;
  typedef logic [OW-1:0] off_t;
  typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;

  state_t            state, state_nxt;
  off_t              in_off;
  logic [1:0]        in_ba;
  logic [1:0]        in_mask;

  logic [1:0]        fifo_ba   [4];
  logic [SDRAMW-1:0] fifo_addr [4];
  logic [7:0]        fifo_byte [4];
  logic [1:0]        fifo_mask [4];
  logic [1:0]        wr_ptr, rd_ptr;
  logic [2:0]        cnt;
  logic              full, empty, pop, push_req, push, drop, load;
  logic              downloading_d;

  // Only the low SDRAMW+1 offset bits matter, so the subtraction is truncated up front.
  always_comb begin
    in_ba  = 2'd3;
    in_off = off_t'(ioctl_addr - BA3_START);
    if (ioctl_addr < BA1_START) begin
      in_ba  = 2'd0;
      in_off = off_t'(ioctl_addr);
    end else if (ioctl_addr < BA2_START) begin
      in_ba  = 2'd1;
      in_off = off_t'(ioctl_addr - BA1_START);
    end else if (ioctl_addr < BA3_START) begin
      in_ba  = 2'd2;
      in_off = off_t'(ioctl_addr - BA2_START);
    end
  end

  assign in_mask  = (in_off[0] ^ SWAB) ? 2'b01 : 2'b10;
  assign full     = (cnt == 3'd4);
  assign empty    = (cnt == 3'd0);
  assign pop      = (state == WRITE) && prog_rdy;
  assign push_req = downloading && ioctl_wr;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;
  assign prog_rd  = 1'b0;

  // The head stays queued while being written, so a full-queue push may reuse its slot on the pop edge.
  always_ff @(posedge clk_rom) begin
    if (push) begin
      fifo_ba[wr_ptr]   <= in_ba;
      fifo_addr[wr_ptr] <= in_off[SDRAMW:1];
      fifo_byte[wr_ptr] <= ioctl_data;
      fifo_mask[wr_ptr] <= in_mask;
    end
  end

  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      cnt    <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 3'd1;
        2'b01:   cnt <= cnt - 3'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        state_nxt = WRITE;
        load      = 1'b1;
      end
      WRITE:   if (prog_rdy) state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prog_addr <= '0;
      prog_data <= 16'd0;
      prog_mask <= 2'd0;
      prog_ba   <= 2'd0;
      prog_we   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        prog_addr <= fifo_addr[rd_ptr];
        prog_data <= {fifo_byte[rd_ptr], fifo_byte[rd_ptr]};
        prog_mask <= fifo_mask[rd_ptr];
        prog_ba   <= fifo_ba[rd_ptr];
        prog_we   <= 1'b1;
      end else if (pop) begin
        prog_we <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      downloading_d <= 1'b0;
      dwnld_busy    <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      downloading_d <= downloading;
      if (downloading)
        dwnld_busy <= 1'b1;
      else if (empty && state == IDLE)
        dwnld_busy <= 1'b0;
      if (downloading && !downloading_d) overflow <= 1'b0;
      if (drop) overflow <= 1'b1;
    end
  end

endmodule
